// File: rtl/pwm_pkg.sv
// Shared constants and elaboration helpers for the multichannel PWM generator.
package pwm_pkg;

  localparam logic PWM_MODE_EDGE   = 1'b0;
  localparam logic PWM_MODE_CENTER = 1'b1;

  // Ceiling log2; returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((32'd1 << r) < 32'(value)) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pwm_btn_debounce.sv
// Two-stage slow-rate sampler for one push-button, emitting one pulse per rising edge.
module pwm_btn_debounce
  import pwm_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic slow_en,
  input  logic btn,
  output logic press
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;

  // Sampler next-state: shift only on the slow enable.
  always_comb begin
    s1_d = s1_q;
    s2_d = s2_q;
    if (slow_en) begin
      s1_d = btn;
      s2_d = s1_q;
    end else begin
      s1_d = s1_q;
      s2_d = s2_q;
    end
  end

  // Sampler registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign press = s1_q & ~s2_q & slow_en;

endmodule

// File: rtl/pwm_multichannel_gen.sv
// NUM_CH PWM outputs sharing one period counter; per-channel duty is button-stepped
// and double-buffered so it only takes effect at the period boundary.
module pwm_multichannel_gen
  import pwm_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int CNT_W     = 8,
  parameter int PERIOD    = 10,
  parameter int STEP      = 1,
  parameter int DUTY_INIT = 5,
  parameter int DEB_DIV   = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       inc_btn,
  input  logic [NUM_CH-1:0]       dec_btn,
  input  logic                    center_mode,
  output logic [NUM_CH-1:0]       pwm_out,
  output logic [NUM_CH*CNT_W-1:0] duty_q,
  output logic                    period_start
);

  localparam int DEB_W = (clog2(DEB_DIV) > 0) ? clog2(DEB_DIV) : 1;
  localparam int DW    = CNT_W + 1;

  localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEB_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_ONE   = DEB_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] DUTY_RST  = CNT_W'(DUTY_INIT);
  localparam logic [CNT_W-1:0] LO_RST    = CNT_W'((PERIOD - DUTY_INIT) / 2);
  localparam logic [CNT_W-1:0] PERIOD_V  = CNT_W'(PERIOD);
  localparam logic [DW-1:0]    PERIOD_X  = DW'(PERIOD);
  localparam logic [DW-1:0]    STEP_X    = DW'(STEP);

  logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mode_act_q, mode_act_d;
  logic [NUM_CH-1:0] pwm_out_q, pwm_out_d;
  logic              period_start_q, period_start_d;
  logic              slow_en;
  logic              bnd;
  logic [NUM_CH-1:0] inc_press, dec_press;

  assign slow_en = (deb_cnt_q == DEB_LAST);
  assign bnd     = (cnt_q == CNT_LAST);

  // Shared prescaler, period counter, mode latch and period marker.
  always_comb begin
    deb_cnt_d      = deb_cnt_q;
    cnt_d          = cnt_q;
    mode_act_d     = mode_act_q;
    period_start_d = (cnt_q == CNT_ZERO);
    if (slow_en) begin
      deb_cnt_d = '0;
    end else begin
      deb_cnt_d = deb_cnt_q + DEB_ONE;
    end
    if (bnd) begin
      cnt_d      = CNT_ZERO;
      mode_act_d = center_mode;
    end else begin
      cnt_d      = cnt_q + CNT_ONE;
      mode_act_d = mode_act_q;
    end
  end

  // Shared state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_cnt_q      <= '0;
      cnt_q          <= CNT_ZERO;
      mode_act_q     <= PWM_MODE_EDGE;
      pwm_out_q      <= '0;
      period_start_q <= 1'b0;
    end else begin
      deb_cnt_q      <= deb_cnt_d;
      cnt_q          <= cnt_d;
      mode_act_q     <= mode_act_d;
      pwm_out_q      <= pwm_out_d;
      period_start_q <= period_start_d;
    end
  end

  assign pwm_out      = pwm_out_q;
  assign period_start = period_start_q;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [CNT_W-1:0] duty_pend_q, duty_pend_d;
    logic [CNT_W-1:0] duty_act_q, duty_act_d;
    logic [CNT_W-1:0] lo_q, lo_d;
    logic [DW-1:0]    pend_ext, pend_sum, act_ext, lo_ext, cnt_ext;
    logic             hit;

    pwm_btn_debounce u_inc (
      .clk    (clk),
      .rst_n  (rst_n),
      .slow_en(slow_en),
      .btn    (inc_btn[k]),
      .press  (inc_press[k])
    );

    pwm_btn_debounce u_dec (
      .clk    (clk),
      .rst_n  (rst_n),
      .slow_en(slow_en),
      .btn    (dec_btn[k]),
      .press  (dec_press[k])
    );

    // Saturating pending-duty update, boundary transfer and compare.
    always_comb begin
      pend_ext    = {1'b0, duty_pend_q};
      pend_sum    = pend_ext + STEP_X;
      act_ext     = {1'b0, duty_act_q};
      lo_ext      = {1'b0, lo_q};
      cnt_ext     = {1'b0, cnt_q};
      duty_pend_d = duty_pend_q;
      duty_act_d  = duty_act_q;
      lo_d        = lo_q;
      hit         = 1'b0;
      if (inc_press[k] && !dec_press[k]) begin
        if (pend_sum > PERIOD_X) begin
          duty_pend_d = PERIOD_V;
        end else begin
          duty_pend_d = pend_sum[CNT_W-1:0];
        end
      end else if (dec_press[k] && !inc_press[k]) begin
        if (pend_ext < STEP_X) begin
          duty_pend_d = CNT_ZERO;
        end else begin
          duty_pend_d = CNT_W'(pend_ext - STEP_X);
        end
      end else begin
        duty_pend_d = duty_pend_q;
      end
      // The boundary takes the pre-press pending value, so a same-cycle press waits a period.
      if (bnd) begin
        duty_act_d = duty_pend_q;
        lo_d       = CNT_W'((PERIOD_X - pend_ext) >> 1'b1);
      end else begin
        duty_act_d = duty_act_q;
        lo_d       = lo_q;
      end
      if (mode_act_q == PWM_MODE_CENTER) begin
        hit = (cnt_ext >= lo_ext) && (cnt_ext < (lo_ext + act_ext));
      end else begin
        hit = (cnt_ext < act_ext);
      end
    end

    // Per-channel duty registers.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        duty_pend_q <= DUTY_RST;
        duty_act_q  <= DUTY_RST;
        lo_q        <= LO_RST;
      end else begin
        duty_pend_q <= duty_pend_d;
        duty_act_q  <= duty_act_d;
        lo_q        <= lo_d;
      end
    end

    assign pwm_out_d[k]                = hit;
    assign duty_q[k*CNT_W +: CNT_W]    = duty_act_q;
  end

endmodule

// File: tb/tb_pwm_multichannel_gen.sv
// Randomised and directed bench for pwm_multichannel_gen with a cycle-level reference model.
module tb_pwm_multichannel_gen;

  localparam int NUM_CH    = 4;
  localparam int CNT_W     = 8;
  localparam int PERIOD    = 10;
  localparam int STEP      = 1;
  localparam int DUTY_INIT = 5;
  localparam int DEB_DIV   = 2;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [NUM_CH-1:0]       inc_btn;
  logic [NUM_CH-1:0]       dec_btn;
  logic                    center_mode;
  logic [NUM_CH-1:0]       pwm_out;
  logic [NUM_CH*CNT_W-1:0] duty_q;
  logic                    period_start;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  pwm_multichannel_gen #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .PERIOD(PERIOD),
    .STEP(STEP), .DUTY_INIT(DUTY_INIT), .DEB_DIV(DEB_DIV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .inc_btn(inc_btn), .dec_btn(dec_btn),
    .center_mode(center_mode), .pwm_out(pwm_out), .duty_q(duty_q),
    .period_start(period_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", nm, got, want, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          tcyc;
  int          pend [NUM_CH];
  int          act  [NUM_CH];
  bit          mode;
  bit          inc_new [NUM_CH], inc_old [NUM_CH];
  bit          dec_new [NUM_CH], dec_old [NUM_CH];
  logic [NUM_CH-1:0] exp_pwm;
  logic        exp_ps;
  int          m_cnt, m_lo;
  bit          m_slow, m_ip, m_dp;

  task automatic model_reset();
    tcyc = 0;
    mode = 1'b0;
    exp_pwm = '0;
    exp_ps = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      pend[k] = DUTY_INIT;
      act[k] = DUTY_INIT;
      inc_new[k] = 1'b0; inc_old[k] = 1'b0;
      dec_new[k] = 1'b0; dec_old[k] = 1'b0;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      m_cnt = tcyc % PERIOD;
      for (int k = 0; k < NUM_CH; k++) begin
        m_lo = (PERIOD - act[k]) / 2;
        exp_pwm[k] = mode ? (m_cnt >= m_lo && m_cnt < m_lo + act[k]) : (m_cnt < act[k]);
      end
      exp_ps = (m_cnt == 0);
      if (m_cnt == PERIOD - 1) begin
        for (int k = 0; k < NUM_CH; k++) act[k] = pend[k];
        mode = center_mode;
      end
      m_slow = ((tcyc % DEB_DIV) == DEB_DIV - 1);
      for (int k = 0; k < NUM_CH; k++) begin
        m_ip = m_slow && inc_new[k] && !inc_old[k];
        m_dp = m_slow && dec_new[k] && !dec_old[k];
        if (m_slow) begin
          inc_old[k] = inc_new[k]; inc_new[k] = inc_btn[k];
          dec_old[k] = dec_new[k]; dec_new[k] = dec_btn[k];
        end
        if (m_ip && !m_dp) pend[k] = (pend[k] + STEP > PERIOD) ? PERIOD : pend[k] + STEP;
        else if (m_dp && !m_ip) pend[k] = (pend[k] < STEP) ? 0 : pend[k] - STEP;
      end
      tcyc++;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("pwm_out", 32'(pwm_out), 32'(exp_pwm));
      chk("period_start", 32'(period_start), 32'(exp_ps));
      for (int k = 0; k < NUM_CH; k++)
        chk($sformatf("duty_q ch%0d", k), 32'(duty_q[k*CNT_W +: CNT_W]), 32'(act[k]));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input bit is_inc, input int ch);
    if (is_inc) inc_btn[ch] = 1'b1; else dec_btn[ch] = 1'b1;
    cycles(4);
    if (is_inc) inc_btn[ch] = 1'b0; else dec_btn[ch] = 1'b0;
    cycles(4);
  endtask

  task automatic wait_ps(output bit ok);
    int w;
    w = 0;
    @(negedge clk);
    while (!period_start && w < 3 * PERIOD) begin
      @(negedge clk);
      w++;
    end
    ok = period_start;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL period_start timeout got 0 want 1 at %0t", $time);
    end
  endtask

  task automatic check_pattern(input string nm, input int ch, input logic [PERIOD-1:0] want);
    logic [PERIOD-1:0] pat;
    bit ok;
    pat = '0;
    wait_ps(ok);
    for (int i = 0; i < PERIOD; i++) begin
      pat[PERIOD-1-i] = pwm_out[ch];
      @(negedge clk);
    end
    chk(nm, 32'(pat), 32'(want));
  endtask

  function automatic int duty_of(input int ch);
    return int'(duty_q[ch*CNT_W +: CNT_W]);
  endfunction

  // ---------------- test sequence ----------------
  bit ok_ps;

  initial begin
    rst_n = 1'b0;
    inc_btn = '0;
    dec_btn = '0;
    center_mode = 1'b0;
    #1 chk_en = 1'b1;
    cycles(3);
    rst_n = 1'b1;

    // Reset defaults and edge waveform.
    for (int k = 0; k < NUM_CH; k++) chk($sformatf("init duty ch%0d", k), 32'(duty_of(k)), 32'd5);
    check_pattern("edge d5 ch0", 0, 10'b1111100000);
    check_pattern("edge d5 ch3", 3, 10'b1111100000);

    // Held inc gives exactly one step.
    inc_btn[0] = 1'b1;
    cycles(40);
    inc_btn[0] = 1'b0;
    cycles(2 * PERIOD);
    chk("held inc ch0", 32'(duty_of(0)), 32'd6);
    chk("held inc ch1 untouched", 32'(duty_of(1)), 32'd5);
    check_pattern("edge d6 ch0", 0, 10'b1111110000);

    // Saturation at PERIOD and at zero.
    for (int i = 0; i < 7; i++) press(1'b1, 1);
    cycles(2 * PERIOD);
    chk("sat high ch1", 32'(duty_of(1)), 32'd10);
    check_pattern("always high ch1", 1, 10'b1111111111);
    for (int i = 0; i < 12; i++) press(1'b0, 1);
    cycles(2 * PERIOD);
    chk("sat low ch1", 32'(duty_of(1)), 32'd0);
    check_pattern("always low ch1", 1, 10'b0000000000);

    // Simultaneous inc/dec cancels; independent channel steps.
    inc_btn[2] = 1'b1; dec_btn[2] = 1'b1; inc_btn[3] = 1'b1;
    cycles(4);
    inc_btn = '0; dec_btn = '0;
    cycles(2 * PERIOD);
    chk("inc+dec ch2", 32'(duty_of(2)), 32'd5);
    chk("inc ch3", 32'(duty_of(3)), 32'd6);

    // Center-aligned patterns and mid-period mode change.
    press(1'b0, 0);
    press(1'b0, 0);
    center_mode = 1'b1;
    cycles(2 * PERIOD);
    chk("ch0 duty 4", 32'(duty_of(0)), 32'd4);
    check_pattern("center d4 ch0", 0, 10'b0001111000);
    press(1'b1, 0);
    cycles(2 * PERIOD);
    check_pattern("center d5 ch0", 0, 10'b0011111000);
    wait_ps(ok_ps);
    cycles(3);
    center_mode = 1'b0;
    chk("mode held mid-period", 32'(pwm_out[0]), 32'd1);
    cycles(1);
    chk("mode held mid-period 2", 32'(pwm_out[0]), 32'd1);
    check_pattern("edge after toggle ch0", 0, 10'b1111100000);

    // Asynchronous reset mid-period.
    press(1'b1, 1);
    cycles(2 * PERIOD);
    wait_ps(ok_ps);
    cycles(3);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst pwm_out", 32'(pwm_out), 32'd0);
    chk("async rst period_start", 32'(period_start), 32'd0);
    chk("async rst duty ch1", 32'(duty_of(1)), 32'd5);
    chk("async rst duty ch3", 32'(duty_of(3)), 32'd5);
    cycles(3);
    rst_n = 1'b1;
    check_pattern("after rst ch0", 0, 10'b1111100000);
    check_pattern("after rst ch3", 3, 10'b1111100000);

    // Random button activity, checked every cycle by the model.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 5) == 0) inc_btn[$urandom_range(0, NUM_CH - 1)] ^= 1'b1;
      if ($urandom_range(0, 5) == 0) dec_btn[$urandom_range(0, NUM_CH - 1)] ^= 1'b1;
      if ($urandom_range(0, 60) == 0) center_mode = ~center_mode;
    end
    inc_btn = '0;
    dec_btn = '0;
    cycles(2 * PERIOD);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
